lpf_channel_scheduler: RTL and testbench
========================================

LPF_CHANNEL_SCHEDULER -- requirements
Module: lpf_channel_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 16: sample width, signed two's complement.
REQ-002 Parameter FRAC_WIDTH, default 8: alpha fractional bits; SCALE = 2^FRAC_WIDTH.
REQ-003 Parameter NUM_CH, default 4: number of requesting channels, range 2..16.
REQ-004 Parameter ALPHA_RST, default 2^(FRAC_WIDTH-1): alpha table reset value.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 in_valid  in  NUM_CH  per-channel sample request.
REQ-008 in_sample  in  NUM_CH x DATA_WIDTH  per-channel signed sample, packed array.
REQ-009 in_ready  out  NUM_CH  one-hot acceptance; at most one bit high per cycle.
REQ-010 cfg_we  in  1  alpha table write strobe.
REQ-011 cfg_ch  in  clog2(NUM_CH)  channel index for cfg_we or clr.
REQ-012 cfg_alpha  in  FRAC_WIDTH  unsigned alpha, 0 <= alpha < 1.
REQ-013 clr  in  1  zero the filter state y of channel cfg_ch.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  downstream accepts result.
REQ-016 out_ch  out  clog2(NUM_CH)  channel of the result.
REQ-017 out_sample  out  DATA_WIDTH  signed filtered result.

Function
REQ-018 One shared one-pole datapath SHALL serve all channels: y_new = (alpha*x + (SCALE-alpha)*y_prev) >>> FRAC_WIDTH, with per-channel y_prev and alpha.
REQ-019 Arithmetic SHALL be signed: alpha and SCALE-alpha zero-extended to FRAC_WIDTH+2 bits; products and sum at DATA_WIDTH+FRAC_WIDTH+2 bits; arithmetic shift; truncation to DATA_WIDTH with no saturation.
REQ-020 FSM states: IDLE, COMPUTE, OUTPUT.
REQ-021 IDLE: if any in_valid, grant via round-robin and assert in_ready for the granted channel in that same cycle; latch sample, channel and that channel's alpha; go to COMPUTE. Otherwise stay in IDLE.
REQ-022 Round-robin: search starts at last_served+1 modulo NUM_CH; last_served updates on each grant.
REQ-023 COMPUTE: one cycle; write y_new into the channel state and output registers; go to OUTPUT.
REQ-024 OUTPUT: out_valid high; out_ch and out_sample held stable until out_valid && out_ready; go to IDLE on that cycle.
REQ-025 Latency from in_valid&&in_ready to out_valid SHALL be 2 cycles; maximum throughput is one sample per 3 cycles.
REQ-026 in_ready SHALL be 0 in COMPUTE and OUTPUT.
REQ-027 cfg_we SHALL write the alpha table in any state; the new alpha applies from the next grant of that channel.
REQ-028 clr SHALL zero y of channel cfg_ch on the next edge. If clr targets the channel being written in COMPUTE, clr wins: state = 0, and the output still presents the computed y_new.
REQ-029 cfg_we and clr in the same cycle SHALL both take effect.
REQ-030 alpha = 0 SHALL hold y_prev; alpha = SCALE-1 SHALL give (x*(SCALE-1) + y_prev) >>> FRAC_WIDTH.

Reset
REQ-031 While rst is high: FSM = IDLE, in_ready = 0, out_valid = 0, out_ch = 0, out_sample = 0, all y = 0, all alpha = ALPHA_RST, last_served = NUM_CH-1 (channel 0 is served first).
REQ-032 rst asserted in COMPUTE or OUTPUT SHALL abort the operation with no result; a pending in-flight state write is discarded.

Structure
REQ-033 Package lpf_pkg SHALL hold the FSM state enum and the SCALE and width-derivation constants.
REQ-034 Sub-module lpf_mac_core SHALL implement REQ-018/019 combinationally (x, y_prev, alpha -> y_new); the scheduler holds the state and alpha tables, arbiter and FSM.

Verification
REQ-035 Step: alpha0 = 0x80; ch0 sends 1000 three times -> outputs 500, 750, 875 on out_ch 0, each 2 cycles after acceptance.
REQ-036 Round-robin: all four in_valid held high -> grant order 0,1,2,3,0,1; in_ready one-hot; a grant every 3 cycles with out_ready = 1.
REQ-037 Backpressure: out_ready low for 5 cycles in OUTPUT -> out_valid, out_ch and out_sample stable; in_ready = 0; accepted on release.
REQ-038 Negative/extremes: alpha = 0x40, y = 0, x = -1024 -> -256; alpha = 0, x = 5000 -> output equals prior y; alpha = 0xFF, x = 32767, y = 0 -> 32639.
REQ-039 clr collision: clr on ch2 during ch2 COMPUTE -> output is computed y_new; next ch2 sample with alpha 0x80 and x = 100 -> 50.
REQ-040 Reset mid-operation: rst in OUTPUT -> out_valid = 0 next cycle; all alpha = 0x80; first grant after reset is ch0.

Source files
------------

// File: rtl/lpf_pkg.sv
// Shared types and width helpers for the multi-channel one-pole low-pass filter.
package lpf_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} lpf_state_e;

  localparam int FRAC_WIDTH_DEF = 8;
  localparam int SCALE_DEF      = 1 << FRAC_WIDTH_DEF;

  function automatic int lpf_scale(input int fw);
    return 1 << fw;
  endfunction

  // Accumulator width: sample plus (FRAC_WIDTH+2)-bit signed coefficient.
  function automatic int lpf_acc_w(input int dw, input int fw);
    return dw + fw + 2;
  endfunction

  function automatic int lpf_ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lpf_mac_core.sv
// Combinational one-pole update: y_new = (a*x + (SCALE-a)*y_prev) >>> FRAC_WIDTH.
module lpf_mac_core
  import lpf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8
)(
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] y_prev,
  input  logic        [FRAC_WIDTH-1:0] alpha,
  output logic signed [DATA_WIDTH-1:0] y_new
);
  localparam int AW    = lpf_acc_w(DATA_WIDTH, FRAC_WIDTH);
  localparam int SCALE = lpf_scale(FRAC_WIDTH);

  logic signed [FRAC_WIDTH+1:0] a_s, b_s;
  logic signed [AW-1:0]         xe, ye, ae, be, acc;

  assign a_s = {2'b00, alpha};
  assign b_s = (FRAC_WIDTH+2)'(SCALE) - a_s;

  assign xe  = {{(AW-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
  assign ye  = {{(AW-DATA_WIDTH){y_prev[DATA_WIDTH-1]}}, y_prev};
  assign ae  = {{(AW-FRAC_WIDTH-2){1'b0}}, a_s};
  assign be  = {{(AW-FRAC_WIDTH-2){1'b0}}, b_s};
  assign acc = xe * ae + ye * be;

  // Truncating narrow: the weighted mean cannot leave the sample range.
  assign y_new = DATA_WIDTH'(acc >>> FRAC_WIDTH);

endmodule

// File: rtl/lpf_channel_scheduler.sv
// Round-robin scheduler sharing one low-pass datapath across NUM_CH channels.
module lpf_channel_scheduler
  import lpf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int ALPHA_RST  = 2 ** (FRAC_WIDTH - 1)
)(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CH-1:0]                    in_valid,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    in_sample,
  output logic [NUM_CH-1:0]                    in_ready,
  input  logic                                 cfg_we,
  input  logic [$clog2(NUM_CH)-1:0]            cfg_ch,
  input  logic [FRAC_WIDTH-1:0]                cfg_alpha,
  input  logic                                 clr,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(NUM_CH)-1:0]            out_ch,
  output logic [DATA_WIDTH-1:0]                out_sample
);
  localparam int CW = lpf_ch_w(NUM_CH);

  lpf_state_e                   state, state_nx;
  logic [CW-1:0]                last_served, grant_idx, cand, ch_q;
  logic                         grant_any;
  logic signed [DATA_WIDTH-1:0] x_q, y_new;
  logic [FRAC_WIDTH-1:0]        alpha_q;
  logic signed [DATA_WIDTH-1:0] y_tbl     [NUM_CH];
  logic [FRAC_WIDTH-1:0]        alpha_tbl [NUM_CH];

  // First requester after last_served wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (state == IDLE) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        cand = CW'((int'(last_served) + i) % NUM_CH);
        if (!grant_any && in_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign in_ready  = (grant_any && !rst) ? (NUM_CH'(1) << grant_idx) : '0;
  assign out_valid = (state == OUTPUT) && !rst;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_any) state_nx = COMPUTE;
      COMPUTE: state_nx = OUTPUT;
      OUTPUT:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  lpf_mac_core #(.DATA_WIDTH(DATA_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_mac (
    .x      (x_q),
    .y_prev (y_tbl[ch_q]),
    .alpha  (alpha_q),
    .y_new  (y_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= CW'(NUM_CH - 1);
      x_q         <= '0;
      ch_q        <= '0;
      alpha_q     <= '0;
      out_ch      <= '0;
      out_sample  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        y_tbl[i]     <= '0;
        alpha_tbl[i] <= FRAC_WIDTH'(ALPHA_RST);
      end
    end else begin
      state <= state_nx;
      if (grant_any) begin
        last_served <= grant_idx;
        x_q         <= in_sample[grant_idx];
        ch_q        <= grant_idx;
        alpha_q     <= alpha_tbl[grant_idx];
      end
      if (state == COMPUTE) begin
        y_tbl[ch_q] <= y_new;
        out_ch      <= ch_q;
        out_sample  <= y_new;
      end
      // Placed after the compute write so a colliding clear takes priority.
      if (clr)    y_tbl[cfg_ch]     <= '0;
      if (cfg_we) alpha_tbl[cfg_ch] <= cfg_alpha;
    end
  end

endmodule

// File: tb/tb_lpf_channel_scheduler.sv
// Directed + randomized bench for lpf_channel_scheduler against an arithmetic reference model.
module tb_lpf_channel_scheduler;
  localparam int DW  = 16;
  localparam int FW  = 8;
  localparam int NCH = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NCH-1:0]           in_valid;
  logic [NCH-1:0][DW-1:0]   in_sample;
  logic [NCH-1:0]           in_ready;
  logic                     cfg_we;
  logic [1:0]               cfg_ch;
  logic [FW-1:0]            cfg_alpha;
  logic                     clr;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               out_ch;
  logic [DW-1:0]            out_sample;

  always #5 clk = ~clk;

  lpf_channel_scheduler #(.DATA_WIDTH(DW), .FRAC_WIDTH(FW), .NUM_CH(NCH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_alpha(cfg_alpha), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_sample(out_sample)
  );

  int checks = 0;
  int failures = 0;
  int y_m [NCH];
  int alpha_m [NCH];
  int last_m;
  int smp [NCH];
  logic signed [DW-1:0] last_out;

  // Reference: weighted average in 64-bit, floor divide by 256, wrap to 16 bits.
  function automatic int filt(input int x, input int y, input int a);
    longint acc;
    longint q;
    logic signed [DW-1:0] t;
    acc = longint'(a) * x + longint'(256 - a) * y;
    q   = acc >>> 8;
    t   = q[DW-1:0];
    return int'(t);
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      y_m[i] = 0;
      alpha_m[i] = 128;
    end
    last_m = NCH - 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '1;
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    tick();
    check("rst_out_ch", out_ch, 0);
    check("rst_out_sample", $signed(out_sample), 0);
    rst = 1'b0;
    in_valid = '0;
    model_reset();
  endtask

  task automatic cfg_write(input int ch, input int a, input bit do_clr);
    cfg_we = 1'b1;
    cfg_ch = ch[1:0];
    cfg_alpha = a[FW-1:0];
    clr = do_clr;
    tick();
    cfg_we = 1'b0;
    clr = 1'b0;
    alpha_m[ch] = a;
    if (do_clr) y_m[ch] = 0;
  endtask

  // One full grant/compute/output transaction; bp = cycles out_ready is held low.
  task automatic xact(input logic [NCH-1:0] mask, input int bp, input bit clr_col);
    int g;
    int e;
    logic [NCH-1:0] oh;
    g = -1;
    for (int i = 1; i <= NCH; i++)
      if (g < 0 && mask[(last_m + i) % NCH]) g = (last_m + i) % NCH;
    for (int i = 0; i < NCH; i++) in_sample[i] = smp[i][DW-1:0];
    in_valid = mask;
    out_ready = (bp == 0);
    #1;
    oh = NCH'(1) << g;
    check("grant", in_ready, oh);
    e = filt(smp[g], y_m[g], alpha_m[g]);
    y_m[g] = clr_col ? 0 : e;
    last_m = g;
    tick();
    in_valid = '0;
    if (clr_col) begin
      clr = 1'b1;
      cfg_ch = g[1:0];
    end
    check("compute_in_ready", in_ready, 0);
    check("compute_out_valid", out_valid, 0);
    tick();
    clr = 1'b0;
    check("out_valid", out_valid, 1);
    check("out_ch", out_ch, g);
    check("out_sample", $signed(out_sample), e);
    last_out = out_sample;
    for (int k = 1; k < bp; k++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_ch", out_ch, g);
      check("bp_out_sample", $signed(out_sample), e);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    in_valid = '0; in_sample = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_alpha = '0;
    clr = 1'b0; out_ready = 1'b1; rst = 1'b1;
    for (int i = 0; i < NCH; i++) smp[i] = 0;
    do_reset();

    // Step response on ch0 with alpha = 0.5
    smp[0] = 1000;
    xact(4'b0001, 0, 0); check("step1", last_out, 500);
    xact(4'b0001, 0, 0); check("step2", last_out, 750);
    xact(4'b0001, 0, 0); check("step3", last_out, 875);

    // Round-robin with every channel requesting
    do_reset();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NCH; i++) smp[i] = int'($urandom_range(0, 65535)) - 32768;
      xact(4'b1111, 0, 0);
      check("rr_order", last_m, n % NCH);
    end

    // Backpressure
    smp[1] = 1234;
    xact(4'b0110, 5, 0);

    // Negative and extreme alphas
    cfg_write(1, 'h40, 1);
    smp[1] = -1024;
    xact(4'b0010, 0, 0); check("neg", last_out, -256);
    cfg_write(2, 'h80, 1);
    smp[2] = 3000;
    xact(4'b0100, 0, 0);
    cfg_write(2, 0, 0);
    smp[2] = 5000;
    xact(4'b0100, 0, 0); check("alpha0_hold", last_out, 1500);
    cfg_write(3, 'hFF, 1);
    smp[3] = 32767;
    xact(4'b1000, 0, 0); check("alpha_max", last_out, 32639);

    // Clear colliding with the compute write of the same channel
    cfg_write(2, 'h80, 0);
    smp[2] = 400;
    xact(4'b0100, 0, 1); check("clr_col_out", last_out, 950);
    smp[2] = 100;
    xact(4'b0100, 0, 0); check("clr_col_next", last_out, 50);

    // Randomized traffic with interleaved alpha writes and clears
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
      for (int i = 0; i < NCH; i++) smp[i] = int'($urandom_range(0, 65535)) - 32768;
      xact(NCH'($urandom_range(1, 15)), int'($urandom_range(0, 2)), bit'($urandom_range(0, 5) == 0));
    end

    // Reset while holding a result in OUTPUT
    cfg_write(0, 'h10, 0);
    in_valid = 4'b1000;
    in_sample[3] = 16'd777;
    out_ready = 1'b0;
    tick();
    in_valid = '0;
    tick();
    check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    model_reset();
    for (int i = 0; i < NCH; i++) smp[i] = 200;
    smp[0] = 1000;
    xact(4'b1111, 0, 0);
    check("post_rst_first_ch", last_m, 0);
    check("post_rst_alpha0", last_out, 500);
    xact(4'b0010, 0, 0); check("post_rst_alpha1", last_out, 100);
    xact(4'b0100, 0, 0); check("post_rst_alpha2", last_out, 100);
    xact(4'b1000, 0, 0); check("post_rst_alpha3", last_out, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
